// File: rtl/pcie_dllp_tx_framer.sv
// Transmit-side DLLP framer: hands the 4-byte body to the CRC stage, waits a fixed
// latency for the CRC, then serialises SDP, body, CRC and END toward the 8b/10b encoder.
module pcie_dllp_tx_framer #(
    parameter int unsigned CRC_LAT    = 1,
    parameter bit          CRC_INVERT = 1'b1,
    parameter logic [7:0]  SDP_SYM    = 8'h5C,
    parameter logic [7:0]  END_SYM    = 8'hFD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_dllp,
    output logic        crc_fd,
    output logic        crc_nd,
    output logic [31:0] crc_d,
    input  logic [15:0] crc_c,
    output logic [7:0]  tx_data,
    output logic        tx_k,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    localparam logic [2:0] LAT = 3'(CRC_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRC  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_body;
    logic [15:0] r_crc;
    logic [2:0]  r_wait;
    logic [2:0]  r_idx;
    logic        r_crc_nd;
    logic [31:0] r_crc_d;
    logic        r_frame_done;
    logic [15:0] r_frames_sent;

    logic        w_accept;
    logic        w_crc_hit;
    logic        w_tx_fire;
    logic        w_last;
    logic [15:0] w_crc_cap;
    logic [7:0]  w_tx_data;
    logic        w_tx_k;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_crc_hit   = 1'b0;
        w_tx_fire   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CRC;
                end
            end
            CRC: begin
                if (r_wait == LAT) begin
                    w_crc_hit   = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    w_tx_fire = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_last      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_crc_cap = CRC_INVERT ? ~crc_c : crc_c;

    // CRC result is sampled purely by cycle count; the CRC stage has no ready handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_body        <= '0;
            r_crc         <= '0;
            r_wait        <= '0;
            r_idx         <= '0;
            r_crc_nd      <= 1'b0;
            r_crc_d       <= '0;
            r_frame_done  <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_crc_nd     <= w_accept;
            r_frame_done <= w_last;
            if (w_accept) begin
                r_body  <= req_dllp;
                r_crc_d <= req_dllp;
                r_wait  <= '0;
            end else if (r_state == CRC && !w_crc_hit) begin
                r_wait <= r_wait + 3'd1;
            end
            if (w_crc_hit) begin
                r_crc <= w_crc_cap;
                r_idx <= '0;
            end else if (w_tx_fire) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_last) begin
                r_frames_sent <= r_frames_sent + 16'd1;
            end
        end
    end

    always_comb begin
        w_tx_data = 8'h00;
        w_tx_k    = 1'b0;
        if (r_state == SEND) begin
            case (r_idx)
                3'd0: begin
                    w_tx_data = SDP_SYM;
                    w_tx_k    = 1'b1;
                end
                3'd1: w_tx_data = r_body[31:24];
                3'd2: w_tx_data = r_body[23:16];
                3'd3: w_tx_data = r_body[15:8];
                3'd4: w_tx_data = r_body[7:0];
                3'd5: w_tx_data = r_crc[15:8];
                3'd6: w_tx_data = r_crc[7:0];
                default: begin
                    w_tx_data = END_SYM;
                    w_tx_k    = 1'b1;
                end
            endcase
        end
    end

    // Symbol outputs decode registered state only, so they stay stable across stalls.
    assign req_ready   = (r_state == IDLE);
    assign crc_nd      = r_crc_nd;
    assign crc_fd      = r_crc_nd;
    assign crc_d       = r_crc_d;
    assign tx_valid    = (r_state == SEND);
    assign tx_data     = w_tx_data;
    assign tx_k        = w_tx_k;
    assign frame_done  = r_frame_done;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_pcie_dllp_tx_framer.sv
// Directed bench for pcie_dllp_tx_framer: one instance at default parameters and one
// with CRC_LAT=3/CRC_INVERT=0, each fed by a stub CRC that is valid only at its latency.
module tb_pcie_dllp_tx_framer;

    logic        clk;
    logic        rstN;
    logic        sel;
    logic        reqValid;
    logic [31:0] reqDllp;
    logic        txReady;
    logic [15:0] crcVal;

    logic        reqReadyA, crcFdA, crcNdA, txKA, txValidA, frameDoneA;
    logic [31:0] crcDA;
    logic [15:0] crcCA, framesSentA;
    logic [7:0]  txDataA;
    logic        reqReadyB, crcFdB, crcNdB, txKB, txValidB, frameDoneB;
    logic [31:0] crcDB;
    logic [15:0] crcCB, framesSentB;
    logic [7:0]  txDataB;
    logic [7:0]  pipeA, pipeB;

    logic        wReqReady, wCrcFd, wCrcNd, wTxK, wTxValid, wFrameDone;
    logic [31:0] wCrcD;
    logic [7:0]  wTxData;
    logic [15:0] wFramesSent;

    typedef struct {
        logic        sel;
        logic [31:0] body;
        logic [15:0] crcv;
        int          readyPct;
        logic [63:0] syms;
        int          lat;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] b2b[3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          firstValid;
    logic [8:0]  symQ[$];
    logic        stallPrev = 1'b0;
    logic [8:0]  stallSym = '0;
    logic [15:0] expA = '0;
    logic [15:0] expB = '0;

    pcie_dllp_tx_framer dutA (
        .clk(clk), .reset(rstN),
        .req_valid(reqValid && !sel), .req_ready(reqReadyA), .req_dllp(reqDllp),
        .crc_fd(crcFdA), .crc_nd(crcNdA), .crc_d(crcDA), .crc_c(crcCA),
        .tx_data(txDataA), .tx_k(txKA), .tx_valid(txValidA), .tx_ready(txReady),
        .frame_done(frameDoneA), .frames_sent(framesSentA)
    );

    pcie_dllp_tx_framer #(.CRC_LAT(3), .CRC_INVERT(1'b0)) dutB (
        .clk(clk), .reset(rstN),
        .req_valid(reqValid && sel), .req_ready(reqReadyB), .req_dllp(reqDllp),
        .crc_fd(crcFdB), .crc_nd(crcNdB), .crc_d(crcDB), .crc_c(crcCB),
        .tx_data(txDataB), .tx_k(txKB), .tx_valid(txValidB), .tx_ready(txReady),
        .frame_done(frameDoneB), .frames_sent(framesSentB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub CRC stages: result present only in the cycle nd + latency, garbage otherwise.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pipeA <= '0;
            pipeB <= '0;
        end else begin
            pipeA <= {pipeA[6:0], crcNdA};
            pipeB <= {pipeB[6:0], crcNdB};
        end
    end
    assign crcCA = pipeA[0] ? crcVal : 16'hDEAD;
    assign crcCB = pipeB[2] ? crcVal : 16'hDEAD;

    assign wReqReady   = sel ? reqReadyB   : reqReadyA;
    assign wCrcFd      = sel ? crcFdB      : crcFdA;
    assign wCrcNd      = sel ? crcNdB      : crcNdA;
    assign wCrcD       = sel ? crcDB       : crcDA;
    assign wTxData     = sel ? txDataB     : txDataA;
    assign wTxK        = sel ? txKB        : txKA;
    assign wTxValid    = sel ? txValidB    : txValidA;
    assign wFrameDone  = sel ? frameDoneB  : frameDoneA;
    assign wFramesSent = sel ? framesSentB : framesSentA;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Samples on the falling edge, then moves to just after the next rising edge.
    task automatic tick(input int readyPct);
        @(negedge clk);
        if (rstN && wTxValid && txReady) symQ.push_back({wTxK, wTxData});
        if (rstN && wTxValid && firstValid < 0) firstValid = cyc;
        if (stallPrev && rstN)
            checkOutput("stall hold", {22'd0, wTxValid, wTxK, wTxData}, {22'd0, 1'b1, stallSym});
        stallPrev = rstN && wTxValid && !txReady;
        stallSym  = {wTxK, wTxData};
        @(posedge clk);
        #1;
        cyc++;
        if (readyPct >= 100) txReady = 1'b1;
        else txReady = (int'($urandom_range(0, 99)) < readyPct);
    endtask

    task automatic applyStimulus(input logic [31:0] body, input logic [15:0] crcv,
                                 input int readyPct, output int acceptCyc);
        int   guard;
        logic busyReady;
        logic ndExtra;
        symQ.delete();
        firstValid = -1;
        crcVal     = crcv;
        reqDllp    = body;
        reqValid   = 1'b1;
        guard      = 0;
        while (!wReqReady && guard < 100) begin
            tick(readyPct);
            guard++;
        end
        checkOutput("accept ready", 32'(wReqReady), 32'd1);
        acceptCyc = cyc;
        tick(readyPct);
        reqValid = 1'b0;
        checkOutput("crc_nd at T+1", 32'(wCrcNd), 32'd1);
        checkOutput("crc_fd at T+1", 32'(wCrcFd), 32'd1);
        checkOutput("crc_d at T+1", wCrcD, body);
        busyReady = 1'b0;
        ndExtra   = 1'b0;
        guard     = 0;
        while (symQ.size() < 8 && guard < 300) begin
            if (wReqReady) busyReady = 1'b1;
            if (wCrcNd && cyc != acceptCyc + 1) ndExtra = 1'b1;
            tick(readyPct);
            guard++;
        end
        checkOutput("symbol count", 32'(symQ.size()), 32'd8);
        checkOutput("req_ready while busy", 32'(busyReady), 32'd0);
        checkOutput("crc_nd extra pulse", 32'(ndExtra), 32'd0);
        checkOutput("frame_done pulse", 32'(wFrameDone), 32'd1);
        checkOutput("req_ready after END", 32'(wReqReady), 32'd1);
        tick(readyPct);
        checkOutput("frame_done clear", 32'(wFrameDone), 32'd0);
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int         acc;
        logic [8:0] e;
        sel = v.sel;
        applyStimulus(v.body, v.crcv, v.readyPct, acc);
        for (int i = 0; i < 8; i++) begin
            e = {(i == 0 || i == 7), v.syms[63-8*i -: 8]};
            checkOutput($sformatf("%s sym%0d", tag, i),
                        32'((symQ.size() > i) ? symQ[i] : 9'h000), 32'(e));
        end
        checkOutput($sformatf("%s tx_valid latency", tag), 32'(firstValid - acc), 32'(v.lat));
        if (v.sel) begin
            expB = expB + 16'd1;
            checkOutput($sformatf("%s frames_sent", tag), 32'(wFramesSent), 32'(expB));
        end else begin
            expA = expA + 16'd1;
            checkOutput($sformatf("%s frames_sent", tag), 32'(wFramesSent), 32'(expA));
        end
    endtask

    function automatic logic [8:0] expSym(input logic [31:0] b, input logic [15:0] c, input int i);
        case (i)
            0: return {1'b1, 8'h5C};
            1: return {1'b0, b[31:24]};
            2: return {1'b0, b[23:16]};
            3: return {1'b0, b[15:8]};
            4: return {1'b0, b[7:0]};
            5: return {1'b0, c[15:8]};
            6: return {1'b0, c[7:0]};
            default: return {1'b1, 8'hFD};
        endcase
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   acc[3];
        int   n;
        int   guard;
        logic accNow;

        vecs[0] = '{1'b0, 32'h0000_0005, 16'h1234, 100, 64'h5C00_0000_05ED_CBFD, 3};
        vecs[1] = '{1'b0, 32'h4012_3456, 16'hA55A, 100, 64'h5C40_1234_565A_A5FD, 3};
        vecs[2] = '{1'b0, 32'h0000_0005, 16'h1234,  30, 64'h5C00_0000_05ED_CBFD, 3};
        vecs[3] = '{1'b0, 32'hDEAD_BEEF, 16'h0000, 100, 64'h5CDE_ADBE_EFFF_FFFD, 3};
        vecs[4] = '{1'b1, 32'h4012_3456, 16'hA55A, 100, 64'h5C40_1234_56A5_5AFD, 5};
        vecs[5] = '{1'b1, 32'h0A0B_0C0D, 16'h00FF,  30, 64'h5C0A_0B0C_0D00_FFFD, 5};
        b2b[0] = 32'h1122_3344;
        b2b[1] = 32'h5566_7788;
        b2b[2] = 32'h99AA_BBCC;

        rstN     = 1'b0;
        sel      = 1'b0;
        reqValid = 1'b0;
        reqDllp  = '0;
        txReady  = 1'b1;
        crcVal   = '0;
        #2;
        checkOutput("reset req_ready", 32'(reqReadyA), 32'd1);
        checkOutput("reset crc_nd/fd", {30'd0, crcNdA, crcFdA}, 32'd0);
        checkOutput("reset crc_d", crcDA, 32'd0);
        checkOutput("reset tx_valid/k", {30'd0, txValidA, txKA}, 32'd0);
        checkOutput("reset tx_data", 32'(txDataA), 32'd0);
        checkOutput("reset frame_done", 32'(frameDoneA), 32'd0);
        checkOutput("reset frames_sent", 32'(framesSentA), 32'd0);
        tick(100);
        rstN = 1'b1;

        for (int v = 0; v < 6; v++) runVector(vecs[v], $sformatf("vec%0d", v));

        // Back-to-back: req_valid held, body swapped right after each accept.
        sel = 1'b0;
        symQ.delete();
        crcVal   = 16'h0F0F;
        reqDllp  = b2b[0];
        reqValid = 1'b1;
        n        = 0;
        guard    = 0;
        while ((n < 3 || symQ.size() < 24) && guard < 100) begin
            accNow = reqValid && wReqReady;
            if (accNow) begin
                acc[n] = cyc;
                n++;
            end
            tick(100);
            guard++;
            if (accNow) begin
                if (n < 3) reqDllp = b2b[n];
                else reqValid = 1'b0;
            end
        end
        checkOutput("b2b accepts", 32'(n), 32'd3);
        checkOutput("b2b spacing 0-1", 32'(acc[1] - acc[0]), 32'd11);
        checkOutput("b2b spacing 1-2", 32'(acc[2] - acc[1]), 32'd11);
        for (int i = 0; i < 24; i++)
            checkOutput($sformatf("b2b sym%0d", i),
                        32'((symQ.size() > i) ? symQ[i] : 9'h000),
                        32'(expSym(b2b[i/8], 16'hF0F0, i % 8)));
        expA = expA + 16'd3;
        checkOutput("b2b frames_sent", 32'(wFramesSent), 32'(expA));
        checkOutput("b2b last frame_done", 32'(wFrameDone), 32'd1);
        tick(100);

        // Reset after idx3 has been accepted.
        sel = 1'b0;
        symQ.delete();
        crcVal   = 16'h1234;
        reqDllp  = 32'h0102_0304;
        reqValid = 1'b1;
        guard    = 0;
        while (!wReqReady && guard < 20) begin
            tick(100);
            guard++;
        end
        tick(100);
        reqValid = 1'b0;
        guard    = 0;
        while (symQ.size() < 4 && guard < 20) begin
            tick(100);
            guard++;
        end
        checkOutput("pre-reset idx4 byte", 32'(wTxData), 32'h04);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("async reset tx_valid", 32'(txValidA), 32'd0);
        checkOutput("async reset req_ready", 32'(reqReadyA), 32'd1);
        checkOutput("async reset frames_sent", 32'(framesSentA), 32'd0);
        checkOutput("async reset tx_data/k", {23'd0, txKA, txDataA}, 32'd0);
        tick(100);
        tick(100);
        rstN = 1'b1;
        expA = '0;
        runVector(vecs[0], "post-reset");

        // Counter wrap from a preloaded 16'hFFFF.
        sel = 1'b0;
        force dutA.r_frames_sent = 16'hFFFF;
        #1;
        release dutA.r_frames_sent;
        checkOutput("preload frames_sent", 32'(framesSentA), 32'hFFFF);
        expA = 16'hFFFF;
        runVector(vecs[3], "wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_dllp_tx_framer.md
# pcie_dllp_tx_framer

Transmit-side DLLP framer for the PCIe data link layer. It accepts a 32-bit DLLP body from the DLLP scheduler and drives it into the `pcie_dllp_crc_32_10001000000001011` stage. It then captures the 16-bit CRC and serialises the complete 8-symbol Gen1/Gen2 DLLP frame as a byte/K-flag stream toward the 8b/10b encoder: SDP, 4 body bytes, 2 CRC bytes, END.

## Interface
Parameters:
- `CRC_LAT`, 1, cycles from the `crc_nd` cycle to the cycle in which `crc_c` is valid; legal range 1..7.
- `CRC_INVERT`, 1, when 1 the transmitted CRC is `~crc_c`; when 0 it is `crc_c` unmodified.
- `SDP_SYM`, 8'h5C, K28.2 start-of-DLLP symbol.
- `END_SYM`, 8'hFD, K29.7 end symbol.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  DLLP body available.
- `req_ready`  out  1  framer can accept a body.
- `req_dllp`  in  32  DLLP body; byte0 (DLLP type) is `[31:24]`, byte3 is `[7:0]`.
- `crc_fd`  out  1  first-data flag to the CRC stage.
- `crc_nd`  out  1  new-data strobe to the CRC stage.
- `crc_d`  out  32  data to the CRC stage.
- `crc_c`  in  16  CRC result from the CRC stage.
- `tx_data`  out  8  symbol byte.
- `tx_k`  out  1  1 = control (K) symbol.
- `tx_valid`  out  1  symbol valid.
- `tx_ready`  in  1  encoder accepts the symbol.
- `frame_done`  out  1  one-cycle pulse when END is accepted.
- `frames_sent`  out  16  count of completed frames; wraps from 16'hFFFF to 0.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - CRC: issue the body to the CRC stage and wait for the result.
  - SEND: emit symbols 0..7.
- IDLE → CRC on `req_valid && req_ready`:
  - latch `req_dllp` into `body_q`;
  - clear the wait counter.
- In the first CRC cycle:
  - `crc_nd` = `crc_fd` = 1 and `crc_d` = `body_q` (registered outputs);
  - both strobes are 0 in every other cycle;
  - `crc_d` holds its last value outside the strobe.
- The wait counter increments each CRC cycle. When it equals `CRC_LAT`:
  - capture `crc_c` (inverted if `CRC_INVERT`) into `crc_q`;
  - set symbol index = 0;
  - go to SEND.
- `crc_rdy` is not used; timing is set solely by `CRC_LAT`.
- SEND symbol order:
  - idx0: `SDP_SYM`, k=1.
  - idx1..4: `body_q[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`, k=0.
  - idx5: `crc_q[15:8]`, k=0.
  - idx6: `crc_q[7:0]`, k=0.
  - idx7: `END_SYM`, k=1.
- The index advances only on `tx_valid && tx_ready`.
- When idx7 is accepted:
  - `frame_done` pulses in the next cycle;
  - `frames_sent` increments (16-bit wrap);
  - state returns to IDLE.
- While in CRC or SEND, `req_ready` = 0 and `req_valid` is ignored; the body is not sampled.

## Timing
- Reset values:
  - `req_ready` = 1 (state IDLE);
  - `crc_fd`, `crc_nd`, `tx_valid`, `tx_k`, `frame_done` = 0;
  - `crc_d`, `tx_data`, `frames_sent`, `body_q`, `crc_q` = 0.
- Latency: with acceptance in cycle T, `crc_nd` is high in T+1 and `crc_c` is captured at the end of T+1+`CRC_LAT`. `tx_valid` rises in T+2+`CRC_LAT` (T+3 at default).
- Minimum frame period with `tx_ready` held at 1: 10+`CRC_LAT` cycles. This is 1 accept + (1+`CRC_LAT`) CRC + 8 SEND.
- Once `tx_valid` is asserted, `tx_data`/`tx_k` must stay stable and `tx_valid` must stay high until accepted.
- `tx_ready` may toggle arbitrarily; stalls only extend SEND.
- Reset asserted mid-frame:
  - all outputs go to reset values immediately (asynchronously);
  - the partial frame is abandoned and no END is emitted;
  - `frames_sent` clears.
- After reset deasserts, the first accept is possible on the first rising edge.
- `req_valid` high in the same cycle the framer returns to IDLE: accepted on the next edge (`req_ready` is registered state, not combinational look-ahead).

## Test plan
- Basic frame: stub CRC returns 16'h1234 at `CRC_LAT`=1; `req_dllp`=32'h00000005; `tx_ready`=1. Required:
  - `crc_nd`/`crc_fd` high exactly in T+1 with `crc_d`=32'h00000005;
  - symbols 5C(k) 00 00 00 05 ED CB FD(k), starting at T+3;
  - `frame_done` pulses once; `frames_sent`=1.
- `CRC_INVERT`=0, `CRC_LAT`=3, stub CRC 16'hA55A, body 32'h4012_3456. Required:
  - CRC bytes A5 5A;
  - `tx_valid` first high at T+5.
- Backpressure: `tx_ready` pseudo-random at 30%. Required:
  - symbol sequence identical to the basic frame;
  - no symbol changes while `tx_valid && !tx_ready`;
  - `req_ready` stays 0 until END is accepted.
- Back-to-back: `req_valid` held high with 3 distinct bodies. Required:
  - three complete frames in order;
  - accept spacing 11 cycles with `tx_ready`=1;
  - `frames_sent`=3.
- Reset mid-frame: assert `reset` low after the idx3 symbol is accepted. Required:
  - `tx_valid`=0 and `req_ready`=1 with no clock edge;
  - `frames_sent`=0;
  - the next frame after release is correct from SDP.
- Counter wrap: preload by sending 65536 frames (or force `frames_sent` to 16'hFFFF), then send one more. Required: `frames_sent`=0 and `frame_done` pulses.
